// File: rtl/fetch_queue_pkg.sv
// Shared encodings and the instruction-queue entry layout for the fetch stage.
package fetch_queue_pkg;

  localparam logic [7:0] ECODE_ADEF    = 8'h08;
  localparam logic       ESUBCODE_ADEF = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
  } fd_entry_t;

  localparam int FD_ENTRY_W = 32 + 32 + 1 + 8 + 1;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Small synchronous FIFO; clear has priority over push and pop.
module fq_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr, wptr;
  logic             full, empty, do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// Multi-outstanding instruction fetch with redirect priority, stale-response
// dropping and an instruction queue in front of pre-decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_en_i,
  input  logic [31:0] ex_entry_pc,
  input  logic        ertn_flush_i,
  input  logic [31:0] ertn_pc,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  output logic        fd_valid,
  input  logic        fd_ready,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_inst,
  output logic        fd_ex,
  output logic [7:0]  fd_ecode,
  output logic        fd_esubcode,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IW = $clog2(IBUF_DEPTH) + 1;

  logic [31:0]   fetch_pc, redir_pc, tag_head;
  logic          halt, any_redir, adef, issue, resp_keep, adef_push, ibuf_push, ibuf_pop;
  logic [OW-1:0] inflight, drop_cnt;
  logic [IW-1:0] ibuf_count;
  fd_entry_t     ibuf_din, ibuf_head;

  always_comb begin
    any_redir = 1'b1;
    redir_pc  = ex_entry_pc;
    if (ex_en_i)           redir_pc = ex_entry_pc;
    else if (ertn_flush_i) redir_pc = ertn_pc;
    else if (br_taken_i)   redir_pc = br_target_i;
    else if (pred_taken_i) redir_pc = pred_target_i;
    else                   any_redir = 1'b0;
  end

  assign adef = |fetch_pc[1:0];

  // Counting in-flight requests against queue space means a response can always be pushed.
  assign inst_sram_req = rstn & ~any_redir & ~halt & ~adef
                       & (int'(inflight) < MAX_OUTSTANDING)
                       & ((int'(inflight) + int'(ibuf_count)) < IBUF_DEPTH);
  assign issue     = inst_sram_req & inst_sram_addr_ok;
  assign resp_keep = inst_sram_data_ok & (drop_cnt == '0) & ~any_redir;
  assign adef_push = adef & ~halt & ~any_redir & (inflight == '0) & (drop_cnt == '0)
                   & (int'(ibuf_count) < IBUF_DEPTH);
  assign ibuf_push = resp_keep | adef_push;

  always_comb begin
    ibuf_din = '{pc: tag_head, inst: inst_sram_rdata, ex: 1'b0, ecode: 8'h00, esubcode: 1'b0};
    if (adef_push)
      ibuf_din = '{pc: fetch_pc, inst: 32'h0, ex: 1'b1, ecode: ECODE_ADEF, esubcode: ESUBCODE_ADEF};
  end

  assign fd_valid    = (ibuf_count != '0) & ~any_redir;
  assign ibuf_pop    = fd_valid & fd_ready;
  assign fd_pc       = fd_valid ? ibuf_head.pc       : 32'h0;
  assign fd_inst     = fd_valid ? ibuf_head.inst     : 32'h0;
  assign fd_ex       = fd_valid & ibuf_head.ex;
  assign fd_ecode    = fd_valid ? ibuf_head.ecode    : 8'h00;
  assign fd_esubcode = fd_valid & ibuf_head.esubcode;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
      halt     <= 1'b0;
      drop_cnt <= '0;
    end else if (any_redir) begin
      fetch_pc <= redir_pc;
      halt     <= 1'b0;
      drop_cnt <= inflight - OW'(inst_sram_data_ok);
    end else begin
      if (issue)     fetch_pc <= fetch_pc + 32'd4;
      if (adef_push) halt     <= 1'b1;
      if (inst_sram_data_ok && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
    end
  end

  // The tag queue occupancy is the in-flight request count.
  fq_sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk   (clk),
    .rstn  (rstn),
    .clear (1'b0),
    .push  (issue),
    .din   (fetch_pc),
    .pop   (inst_sram_data_ok),
    .head  (tag_head),
    .count (inflight)
  );

  fq_sync_fifo #(.WIDTH(FD_ENTRY_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .rstn  (rstn),
    .clear (any_redir),
    .push  (ibuf_push),
    .din   (ibuf_din),
    .pop   (ibuf_pop),
    .head  (ibuf_head),
    .count (ibuf_count)
  );

endmodule
